// File: rtl/lock_key_loader_pkg.sv
// Shared constants and types for the c432 key loader: key geometry,
// FSM state encoding and the packed key layout.
package lock_key_pkg;

  localparam int MUX_KEY_W = 4;                      // p1..p4
  localparam int XOR_KEY_W = 26;                     // X_1..X_26
  localparam int KEY_W     = MUX_KEY_W + XOR_KEY_W;  // 30
  localparam int CNT_W     = 5;                      // 2**CNT_W must exceed KEY_W

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_CHECK  = 3'd2,
    ST_LOADED = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  // Field order mirrors the shift register: mux bits occupy the low end.
  typedef struct packed {
    logic [XOR_KEY_W-1:0] xor_bits;
    logic [MUX_KEY_W-1:0] mux;
  } key_t;

endpackage

// File: rtl/lock_key_loader_if.sv
// Serial key stream from the on-chip key store: one bit per valid/ready
// transfer. The key store is the master, the loader the slave.
interface lock_key_loader_if;

  logic key_sdata;
  logic key_svalid;
  logic key_sready;

  modport master (
    output key_sdata,
    output key_svalid,
    input  key_sready
  );

  modport slave (
    input  key_sdata,
    input  key_svalid,
    output key_sready
  );

endinterface

// File: rtl/lock_key_loader_key_shift_acc.sv
// LSB-first key shift register with bit counter and running parity.
// load folds the offered bit into the parity; shift_en also stores it at
// the position given by the counter and advances the counter.
module key_shift_acc
  import lock_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [KEY_W-1:0] shreg,
  output logic             last_bit,
  output logic             par
);

  logic [CNT_W-1:0] cnt_reg;
  logic [KEY_W-1:0] shreg_reg;
  logic             par_reg;

  // Bit counter: index of the next key bit to be stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt_reg <= '0;
    else if (clear)    cnt_reg <= '0;
    else if (shift_en) cnt_reg <= cnt_reg + CNT_W'(1);
  end

  // Running even-parity accumulator over every accepted bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     par_reg <= 1'b0;
    else if (clear) par_reg <= 1'b0;
    else if (load)  par_reg <= par_reg ^ bit_in;
  end

  // Each key bit captures the stream only when the counter points at it,
  // so bit n of the stream always lands in shreg[n].
  generate
    for (genvar gi = 0; gi < KEY_W; gi++) begin : g_bit
      // Capture stream bit gi.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          shreg_reg[gi] <= 1'b0;
        else if (clear)
          shreg_reg[gi] <= 1'b0;
        else if (shift_en && (cnt_reg == CNT_W'(gi)))
          shreg_reg[gi] <= bit_in;
      end
    end
  endgenerate

  assign shreg    = shreg_reg;
  assign last_bit = (cnt_reg == CNT_W'(KEY_W - 1));
  assign par      = par_reg;

endmodule

// File: rtl/lock_key_loader.sv
// Key loader top: accepts the 30-bit unlock key plus an even-parity bit,
// and exposes the key on registered outputs only after a parity-clean load.
module lock_key_loader
  import lock_key_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 zeroize,
  lock_key_loader_if.slave     key_stream,
  output logic [MUX_KEY_W-1:0] key_mux,
  output logic [XOR_KEY_W-1:0] key_xor,
  output logic                 key_valid,
  output logic                 key_err,
  output logic                 busy
);

  localparam logic [2:0] IDLE   = 3'(ST_IDLE);
  localparam logic [2:0] SHIFT  = 3'(ST_SHIFT);
  localparam logic [2:0] CHECK  = 3'(ST_CHECK);
  localparam logic [2:0] LOADED = 3'(ST_LOADED);
  localparam logic [2:0] ERROR  = 3'(ST_ERROR);

  logic [2:0]       state_reg, state_next;
  key_t             key_reg, key_next;
  logic             key_valid_reg, key_valid_next;
  logic             key_err_reg, key_err_next;

  logic             in_load;
  logic             xfer;
  logic             acc_clear;
  logic             acc_load;
  logic             acc_shift;
  logic [KEY_W-1:0] shreg;
  logic             last_bit;
  logic             par;

  // Ready is a pure function of state so the source never sees a
  // combinational path from its own valid.
  assign in_load = (state_reg == SHIFT) || (state_reg == CHECK);
  assign xfer    = key_stream.key_svalid && in_load;

  // zeroize wins over any transfer offered in the same cycle.
  assign acc_load  = xfer && !zeroize;
  assign acc_shift = acc_load && (state_reg == SHIFT);

  key_shift_acc u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (acc_clear),
    .load     (acc_load),
    .shift_en (acc_shift),
    .bit_in   (key_stream.key_sdata),
    .shreg    (shreg),
    .last_bit (last_bit),
    .par      (par)
  );

  // Next-state and output decisions; zeroize first, then start, then data.
  always_comb begin
    state_next     = state_reg;
    key_next       = key_reg;
    key_valid_next = key_valid_reg;
    key_err_next   = key_err_reg;
    acc_clear      = 1'b0;
    if (zeroize) begin
      state_next     = IDLE;
      key_next       = '0;
      key_valid_next = 1'b0;
      key_err_next   = 1'b0;
      acc_clear      = 1'b1;
    end else begin
      case (state_reg)
        IDLE, LOADED, ERROR: begin
          // Outputs clear on the same edge so a partial key is never visible.
          if (start) begin
            state_next     = SHIFT;
            key_next       = '0;
            key_valid_next = 1'b0;
            key_err_next   = 1'b0;
            acc_clear      = 1'b1;
          end
        end
        SHIFT: begin
          if (xfer && last_bit) state_next = CHECK;
        end
        CHECK: begin
          if (xfer) begin
            if (par ^ key_stream.key_sdata) begin
              state_next     = ERROR;
              key_next       = '0;
              key_valid_next = 1'b0;
              key_err_next   = 1'b1;
            end else begin
              state_next     = LOADED;
              key_next       = key_t'(shreg);
              key_valid_next = 1'b1;
              key_err_next   = 1'b0;
            end
          end
        end
        default: begin
          state_next     = IDLE;
          key_next       = '0;
          key_valid_next = 1'b0;
          key_err_next   = 1'b0;
        end
      endcase
    end
  end

  // State and registered key/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      key_reg       <= '0;
      key_valid_reg <= 1'b0;
      key_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      key_reg       <= key_next;
      key_valid_reg <= key_valid_next;
      key_err_reg   <= key_err_next;
    end
  end

  assign key_stream.key_sready = in_load;
  assign busy      = in_load;
  assign key_mux   = key_reg.mux;
  assign key_xor   = key_reg.xor_bits;
  assign key_valid = key_valid_reg;
  assign key_err   = key_err_reg;

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed plus randomized bench for lock_key_loader. Expected outputs come
// from a key-level model: a load is good when the key bits and parity bit
// XOR to zero, and a good key splits into its low 4 and high 26 bits.
module tb_lock_key_loader;
  import lock_key_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 zeroize;
  logic [MUX_KEY_W-1:0] key_mux;
  logic [XOR_KEY_W-1:0] key_xor;
  logic                 key_valid;
  logic                 key_err;
  logic                 busy;

  lock_key_loader_if kif ();

  lock_key_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .zeroize    (zeroize),
    .key_stream (kif),
    .key_mux    (key_mux),
    .key_xor    (key_xor),
    .key_valid  (key_valid),
    .key_err    (key_err),
    .busy       (busy)
  );

  int errors = 0;
  int checks = 0;

  // Model of what the outputs should currently show.
  logic                 m_valid;
  logic                 m_err;
  logic [MUX_KEY_W-1:0] m_mux;
  logic [XOR_KEY_W-1:0] m_xor;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"}, 64'(key_valid), 64'(m_valid));
    check({tag, "_err"},   64'(key_err),   64'(m_err));
    check({tag, "_mux"},   64'(key_mux),   64'(m_mux));
    check({tag, "_xor"},   64'(key_xor),   64'(m_xor));
  endtask

  // One complete load. stall_mode: 0 none, 1 one idle cycle before each
  // bit, 2 random idle cycles. start is re-pulsed during bit start_at.
  task automatic do_load(input logic [KEY_W-1:0] key, input logic pbit,
                         input int stall_mode, input int start_at);
    logic good;
    good = ((^key) ^ pbit) == 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_valid = 1'b0; m_err = 1'b0; m_mux = '0; m_xor = '0;
    check("start_busy", 64'(busy), 64'd1);
    check_model("after_start");
    for (int i = 0; i <= KEY_W; i++) begin
      int gap;
      gap = (stall_mode == 1) ? 1 : (stall_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gap; g++) begin
        kif.key_svalid = 1'b0;
        kif.key_sdata  = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      check("sready_in_load", 64'(kif.key_sready), 64'd1);
      kif.key_svalid = 1'b1;
      kif.key_sdata  = (i < KEY_W) ? key[i] : pbit;
      if (i == start_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (i < KEY_W) check("valid_during_load", 64'(key_valid), 64'd0);
    end
    kif.key_svalid = 1'b0;
    m_valid = good;
    m_err   = !good;
    m_mux   = good ? key[MUX_KEY_W-1:0] : '0;
    m_xor   = good ? key[KEY_W-1:MUX_KEY_W] : '0;
    check_model("after_parity");
    check("idle_busy", 64'(busy), 64'd0);
    $display("load key=%08h parity=%0d good=%0d valid=%0d err=%0d mux=%0h xor=%07h",
             key, pbit, good, key_valid, key_err, key_mux, key_xor);
  endtask

  // Offer bits while not loading; nothing may change.
  task automatic offer_extra(input int n);
    for (int i = 0; i < n; i++) begin
      kif.key_svalid = 1'b1;
      kif.key_sdata  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("extra_sready", 64'(kif.key_sready), 64'd0);
      check_model("extra");
    end
    kif.key_svalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; zeroize = 1'b0;
    kif.key_sdata = 1'b0; kif.key_svalid = 1'b0;
    m_valid = 1'b0; m_err = 1'b0; m_mux = '0; m_xor = '0;
    @(negedge clk);
    @(negedge clk);
    check_model("in_reset");
    check("reset_sready", 64'(kif.key_sready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_model("post_reset");
    check("post_reset_busy", 64'(busy), 64'd0);
    offer_extra(2);

    // Clean load of the reference key.
    do_load(30'h15555555, 1'b1, 0, -1);
    check("clean_mux_const", 64'(key_mux), 64'h5);
    check("clean_xor_const", 64'(key_xor), 64'h1555555);
    offer_extra(3);

    // Parity failure.
    do_load(30'h15555555, 1'b0, 0, -1);
    check("perr_err_const", 64'(key_err), 64'd1);
    offer_extra(2);

    // Alternating stalls.
    do_load(30'h3FFFFFFF, 1'b0, 1, -1);
    check("stall_xor_const", 64'(key_xor), 64'h3FFFFFF);

    // Reload from LOADED (outputs clear inside do_load), with an ignored
    // start pulse at bit 10.
    do_load(30'h2A5C3E71, ^(30'h2A5C3E71), 0, 10);

    // Zeroize in LOADED.
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    m_valid = 1'b0; m_err = 1'b0; m_mux = '0; m_xor = '0;
    check_model("zeroize_loaded");

    // Zeroize mid-stream together with an offered bit.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      kif.key_svalid = 1'b1; kif.key_sdata = 1'b1;
      @(negedge clk);
    end
    zeroize = 1'b1; kif.key_sdata = 1'b1;
    @(negedge clk);
    zeroize = 1'b0; kif.key_svalid = 1'b0;
    check("zeroize_busy", 64'(busy), 64'd0);
    check("zeroize_sready", 64'(kif.key_sready), 64'd0);
    check_model("zeroize_mid");
    offer_extra(2);
    do_load(30'h0000000F, 1'b0, 0, -1);

    // Async reset after 12 bits of a load.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      kif.key_svalid = 1'b1; kif.key_sdata = 1'b1;
      @(negedge clk);
    end
    kif.key_svalid = 1'b0;
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    m_valid = 1'b0; m_err = 1'b0; m_mux = '0; m_xor = '0;
    check("async_busy", 64'(busy), 64'd0);
    check("async_sready", 64'(kif.key_sready), 64'd0);
    check_model("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_load(30'h00000001, 1'b1, 0, -1);
    check("after_reset_mux", 64'(key_mux), 64'h1);
    check("after_reset_xor", 64'(key_xor), 64'h0);

    // Randomized loads with random parity bits and random stalls.
    for (int n = 0; n < 16; n++) begin
      logic [KEY_W-1:0] rkey;
      logic             rpar;
      rkey = KEY_W'($urandom);
      rpar = 1'($urandom_range(0, 1));
      do_load(rkey, rpar, 2, (n % 4 == 0) ? int'($urandom_range(0, KEY_W)) : -1);
      if (n % 3 == 0) offer_extra(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lock_key_loader.md
Name: lock_key_loader

Overview:
- Upstream key-provisioning stage for the key-locked c432 netlist.
- Receives the 30-bit unlock key serially from the on-chip key store over a valid/ready stream, checks an even-parity bit, and holds the key on parallel outputs.
  - The 4 mux-select key bits drive the p1..p4 inputs.
  - The 26 XOR key bits drive X_1..X_26.
- Key outputs stay zeroed until a parity-clean load completes, and are zeroed again on zeroize.

Parameters:
- MUX_KEY_W, 4, number of mux-select key bits (p1..p4).
- XOR_KEY_W, 26, number of XOR key-gate bits (X_1..X_26).
- KEY_W, MUX_KEY_W+XOR_KEY_W (30), total key length in bits.
- CNT_W, 5, bit-counter width; must satisfy 2**CNT_W > KEY_W.

Ports:
- clk  input  1  single clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a key load; honoured only in IDLE, LOADED or ERROR.
- zeroize  input  1  synchronous clear of the key and status; returns the FSM to IDLE.
- key_sdata  input  1  serial key bit.
- key_svalid  input  1  key_sdata is valid this cycle.
- key_sready  output  1  loader accepts a bit this cycle.
- key_mux  output  MUX_KEY_W  mux-select key; bit i drives p(i+1).
- key_xor  output  XOR_KEY_W  XOR key; bit i drives X_(i+1).
- key_valid  output  1  key outputs hold a parity-checked key.
- key_err  output  1  last load failed its parity check.
- busy  output  1  a load is in progress (SHIFT or CHECK).

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; shift register and bit counter clear.
  - key_mux=0, key_xor=0, key_valid=0, key_err=0, busy=0, key_sready=0.
- FSM states: IDLE, SHIFT, CHECK, LOADED, ERROR.
- IDLE: key_sready=0. On start, go to SHIFT, clear the counter, clear the shift register and key_err.
- SHIFT:
  - key_sready=1 and busy=1.
  - A bit transfers when key_svalid && key_sready. Received bit n (n=0..KEY_W-1) is stored at shift-register bit n, LSB first.
  - The running parity accumulator XORs every transferred bit.
  - After the transfer with counter==KEY_W-1, go to CHECK.
  - Cycles with key_svalid=0 stall with no state change; there is no timeout.
- CHECK:
  - key_sready=1 and busy=1; waits for exactly one more transferred bit, the parity bit.
  - If the accumulator XOR the parity bit == 0, go to LOADED. Otherwise go to ERROR.
- LOADED:
  - On the entry edge, key_mux <= shreg[MUX_KEY_W-1:0] and key_xor <= shreg[KEY_W-1:MUX_KEY_W].
  - key_valid=1 starting the cycle after the parity transfer, so total latency is KEY_W+1 accepted transfers plus 1 cycle.
  - Key outputs are registered and stable; they change only on the next successful load, zeroize or reset.
- ERROR: key_err=1, key_valid=0, key_mux and key_xor forced to 0.
- start in LOADED or ERROR:
  - Go to SHIFT. key_valid drops to 0 and the outputs clear to 0 on the same edge, so no partially shifted key is ever exposed.
- start in SHIFT or CHECK: ignored.
- zeroize:
  - Highest priority over start and over a data transfer in the same cycle.
  - Next edge: IDLE, with all outputs at their reset values.
- Extra bits offered after CHECK (key_svalid=1 in IDLE/LOADED/ERROR): not accepted (key_sready=0) and have no effect.
- Reset mid-load: immediate async clear; the next load must restart from bit 0.
- key_sready depends on state only, never combinationally on key_svalid.

Decomposition:
- Package lock_key_pkg holds:
  - the FSM state enum;
  - MUX_KEY_W, XOR_KEY_W and KEY_W constants;
  - a packed key_t struct with mux (MUX_KEY_W bits) and xor (XOR_KEY_W bits) fields.
- One sub-module, key_shift_acc: the LSB-first shift register, bit counter and parity accumulator, with load/clear/shift_en inputs and last_bit/par outputs.
- The FSM and output registers live in the top.

Test Plan:
- Clean load: start, stream 30'h15555555 LSB first then parity=1, key_svalid held high -> key_valid=1 on the cycle after the parity transfer; key_mux=4'h5, key_xor=26'h1555555, key_err=0.
- Parity fail: same key with parity=0 -> state ERROR, key_err=1, key_valid=0, key_mux=0, key_xor=0.
- Stalls: clean load of 30'h3FFFFFFF (parity 0) with key_svalid toggling 1/0 every cycle -> same final key as an unstalled load; key_valid asserts exactly 1 cycle after the 31st accepted bit.
- Reload and zeroize: after a good load, start -> key_valid=0 and outputs 0 on the next edge; mid-stream zeroize together with key_svalid=1 -> IDLE, bit ignored, all outputs 0.
- Async reset mid-SHIFT after 12 bits: rst_n low for 1 cycle -> outputs 0 immediately; a fresh full load of 30'h00000001 (parity 1) -> key_mux=4'h1, key_xor=0.
- Ignored start: pulse start at bit 10 of a load -> load continues, 31 transfers total, correct key latched.
